// File: rtl/stage2_pkg.sv
// -----------------------------------------------------------------------------
// stage2_pkg
// Shared definitions for encoder stage 2: scheduler state encoding, default
// operand widths, the RR extraction shift and the v_bool offset constant.
// -----------------------------------------------------------------------------
package stage2_pkg;

   localparam int unsigned S2_RANGE_WIDTH   = 16;
   localparam int unsigned S2_SYMBOL_WIDTH  = 4;
   localparam int unsigned S2_BOOL_V_OFFSET = 4;
   // RR is the top byte of the current range.
   localparam int unsigned S2_RR_SHIFT      = 8;
   localparam int unsigned S2_RES_WIDTH     = S2_RANGE_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL_V = 2'd1,
      ST_MUL_U = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage : stage2_pkg

// File: rtl/stage_2_mult_scheduler.sv
// -----------------------------------------------------------------------------
// stage_2_mult_scheduler
// Time-multiplexes one shared RANGE_WIDTH x RANGE_WIDTH multiplier across the
// R*V and R*U products of encoder stage 2. One product is formed per cycle;
// boolean symbols only need R*V, so the R*U cycle is skipped for them.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake for one operand set
//   in_range          current range, RR = in_range >> 8
//   UU, VV            CDF-derived multiplicands
//   lut_u, lut_v      additive LUT terms
//   COMP_mux_1        pass-through flag
//   bool              1 = boolean symbol (V product only)
//   symbol            pass-through symbol, bit 0 forwarded
//   mult_a/mult_b     operands to the shared multiplier (0 when idle)
//   mult_r            combinational product from the shared multiplier
//   out_valid/out_ready downstream handshake for one result set
//   u, v, v_bool      registered results ((R*X)>>1 + term, low RES bits)
//   out_range, out_comp, out_bool_symbol  registered pass-through fields
// -----------------------------------------------------------------------------
module stage_2_mult_scheduler
   import stage2_pkg::*;
#(
   parameter int unsigned RANGE_WIDTH   = S2_RANGE_WIDTH,
   parameter int unsigned SYMBOL_WIDTH  = S2_SYMBOL_WIDTH,
   parameter int unsigned BOOL_V_OFFSET = S2_BOOL_V_OFFSET
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [RANGE_WIDTH-1:0]      in_range,
   input  logic [RANGE_WIDTH-1:0]      UU,
   input  logic [RANGE_WIDTH-1:0]      VV,
   input  logic [RANGE_WIDTH-1:0]      lut_u,
   input  logic [RANGE_WIDTH-1:0]      lut_v,
   input  logic                        COMP_mux_1,
   input  logic                        bool,
   input  logic [SYMBOL_WIDTH-1:0]     symbol,
   output logic [RANGE_WIDTH-1:0]      mult_a,
   output logic [RANGE_WIDTH-1:0]      mult_b,
   input  logic [2*RANGE_WIDTH-1:0]    mult_r,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [RANGE_WIDTH:0]        u,
   output logic [RANGE_WIDTH:0]        v,
   output logic [RANGE_WIDTH:0]        v_bool,
   output logic [RANGE_WIDTH-1:0]      out_range,
   output logic                        out_comp,
   output logic [1:0]                  out_bool_symbol
);

   localparam int unsigned PW    = 2 * RANGE_WIDTH;
   localparam int unsigned RES_W = RANGE_WIDTH + 1;

   state_e state_q, state_d;

   // Operand registers captured on accept.
   logic [RANGE_WIDTH-1:0] rr_q;
   logic [RANGE_WIDTH-1:0] uu_q;
   logic [RANGE_WIDTH-1:0] vv_q;
   logic [RANGE_WIDTH-1:0] lut_u_q;
   logic [RANGE_WIDTH-1:0] lut_v_q;
   logic [RANGE_WIDTH-1:0] range_q;
   logic                   comp_q;
   logic                   bool_q;
   logic                   sym0_q;

   // Result registers.
   logic [RES_W-1:0]       u_q;
   logic [RES_W-1:0]       v_q;
   logic [RES_W-1:0]       vb_q;

   logic                   accept;
   logic [PW-1:0]          half_prod;
   logic [RES_W-1:0]       u_res;
   logic [RES_W-1:0]       v_res;
   logic [RES_W-1:0]       vb_res;

   // Only symbol[0] travels downstream; the remaining bits are intentionally dropped.
   logic                   unused_symbol;
   assign unused_symbol = ^symbol;

   // ---------------------------------------------------------------------------
   // Next-state, handshake and multiplier operand selection
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      mult_a   = '0;
      mult_b   = '0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_MUL_V: begin
            mult_a  = rr_q;
            mult_b  = vv_q;
            state_d = bool_q ? ST_DONE : ST_MUL_U;
         end
         ST_MUL_U: begin
            mult_a  = rr_q;
            mult_b  = uu_q;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // A downstream consume frees the result slot, so a new operand
            // set can be taken in the same cycle without a bubble.
            if (out_ready) begin
               in_ready = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // No handshake is offered while reset is asserted.
      if (reset) begin
         in_ready = 1'b0;
      end

      accept = in_valid && in_ready;
      if (accept) begin
         state_d = ST_MUL_V;
      end
   end

   // ---------------------------------------------------------------------------
   // Result arithmetic: sums at product width, truncated to RES_W bits
   // ---------------------------------------------------------------------------
   always_comb begin
      half_prod = mult_r >> 1;
      v_res     = RES_W'(half_prod + PW'(lut_v_q));
      vb_res    = RES_W'(half_prod + PW'(BOOL_V_OFFSET));
      u_res     = RES_W'(half_prod + PW'(lut_u_q));
   end

   // ---------------------------------------------------------------------------
   // State, operand and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         uu_q    <= '0;
         vv_q    <= '0;
         lut_u_q <= '0;
         lut_v_q <= '0;
         range_q <= '0;
         comp_q  <= 1'b0;
         bool_q  <= 1'b0;
         sym0_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
         vb_q    <= '0;
      end else begin
         state_q <= state_d;

         if (accept) begin
            rr_q    <= in_range >> S2_RR_SHIFT;
            uu_q    <= UU;
            vv_q    <= VV;
            lut_u_q <= lut_u;
            lut_v_q <= lut_v;
            range_q <= in_range;
            comp_q  <= COMP_mux_1;
            bool_q  <= bool;
            sym0_q  <= symbol[0];
         end

         if (state_q == ST_MUL_V) begin
            v_q  <= v_res;
            vb_q <= vb_res;
            // Boolean symbols never reach MUL_U; clear u here instead.
            if (bool_q) begin
               u_q <= '0;
            end
         end

         if (state_q == ST_MUL_U) begin
            u_q <= u_res;
         end
      end
   end

   assign out_valid       = (state_q == ST_DONE);
   assign u               = u_q;
   assign v               = v_q;
   assign v_bool          = vb_q;
   assign out_range       = range_q;
   assign out_comp        = comp_q;
   assign out_bool_symbol = {bool_q, sym0_q};

endmodule : stage_2_mult_scheduler

// File: tb/tb_stage_2_mult_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stage_2_mult_scheduler
// Directed, table-driven bench for the stage-2 multiplier scheduler. The
// shared multiplier is modelled combinationally. Vector expectations are
// hand-computed as ((RR*X)>>1 + term) & 0x1FFFF with RR = range >> 8.
// -----------------------------------------------------------------------------
module tb_stage_2_mult_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_range, UU, VV, lut_u, lut_v;
   logic        COMP_mux_1;
   logic        bool_s;
   logic [3:0]  symbol;
   logic [15:0] mult_a, mult_b;
   logic [31:0] mult_r;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] u, v, v_bool;
   logic [15:0] out_range;
   logic        out_comp;
   logic [1:0]  out_bool_symbol;

   stage_2_mult_scheduler #(
      .RANGE_WIDTH   (16),
      .SYMBOL_WIDTH  (4),
      .BOOL_V_OFFSET (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_range        (in_range),
      .UU              (UU),
      .VV              (VV),
      .lut_u           (lut_u),
      .lut_v           (lut_v),
      .COMP_mux_1      (COMP_mux_1),
      .bool            (bool_s),
      .symbol          (symbol),
      .mult_a          (mult_a),
      .mult_b          (mult_b),
      .mult_r          (mult_r),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .u               (u),
      .v               (v),
      .v_bool          (v_bool),
      .out_range       (out_range),
      .out_comp        (out_comp),
      .out_bool_symbol (out_bool_symbol)
   );

   // Shared multiplier model: combinational, same cycle.
   assign mult_r = 32'(mult_a) * 32'(mult_b);

   typedef struct {
      logic [15:0] rng;
      logic [15:0] uu;
      logic [15:0] vv;
      logic [15:0] lu;
      logic [15:0] lv;
      logic        comp;
      logic        bl;
      logic [3:0]  sym;
      logic [16:0] eu;
      logic [16:0] ev;
      logic [16:0] evb;
      logic [1:0]  ebs;
   } vec_t;

   vec_t vecs [6];

   int unsigned passed = 0;
   int unsigned total  = 0;

   // Watches mult_b during a boolean symbol for any cycle that used UU.
   logic        mon_en  = 1'b0;
   logic        mon_hit = 1'b0;
   logic [15:0] mon_uu  = '0;
   always @(negedge clk) begin
      if (mon_en && (mult_b == mon_uu)) mon_hit = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input vec_t t);
      in_range   = t.rng;
      UU         = t.uu;
      VV         = t.vv;
      lut_u      = t.lu;
      lut_v      = t.lv;
      COMP_mux_1 = t.comp;
      bool_s     = t.bl;
      symbol     = t.sym;
   endtask

   // Presents one vector, waits for accept, then counts cycles until
   // out_valid (cycle 1 is the one right after the accept edge).
   task automatic send(input int idx, output int lat);
      int n;
      @(negedge clk);
      drive(vecs[idx]);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   initial begin
      int lat;
      int beats;
      int k_in;
      int last_c;
      bit acc_last;
      int seq [4];

      vecs[0] = '{16'h8000, 16'h0200, 16'h0100, 16'h0008, 16'h0004, 1'b1, 1'b0, 4'h5,
                  17'h08008, 17'h04004, 17'h04004, 2'b01};
      vecs[1] = '{16'hFF00, 16'h1234, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h1,
                  17'h00000, 17'h07F80, 17'h07F84, 2'b11};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'h2,
                  17'h00000, 17'h07F7F, 17'h17F84, 2'b00};
      vecs[3] = '{16'h1234, 16'h0005, 16'h0003, 16'h0100, 16'h0010, 1'b0, 1'b0, 4'hF,
                  17'h0012D, 17'h0002B, 17'h0001F, 2'b01};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 4'h3,
                  17'h07F7F, 17'h00100, 17'h00103, 2'b01};
      vecs[5] = '{16'h0300, 16'hBEEF, 16'h0007, 16'h0000, 16'h0005, 1'b1, 1'b1, 4'h0,
                  17'h00000, 17'h0000F, 17'h0000E, 2'b10};
      seq = '{0, 2, 3, 4};

      // ---------------- reset state ----------------
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_u",         32'(u),         32'd0);
      check("rst_v",         32'(v),         32'd0);
      check("rst_v_bool",    32'(v_bool),    32'd0);
      check("rst_range",     32'(out_range), 32'd0);
      check("rst_comp",      32'(out_comp),  32'd0);
      check("rst_bs",        32'(out_bool_symbol), 32'd0);
      check("rst_mult_a",    32'(mult_a),    32'd0);
      check("rst_mult_b",    32'(mult_b),    32'd0);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 6; i++) begin
         mon_uu  = vecs[i].uu;
         mon_hit = 1'b0;
         mon_en  = vecs[i].bl;
         send(i, lat);
         mon_en  = 1'b0;
         check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].bl ? 32'd2 : 32'd3);
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("v%0d_u", i), 32'(u), 32'(vecs[i].eu));
         check($sformatf("v%0d_v", i), 32'(v), 32'(vecs[i].ev));
         check($sformatf("v%0d_v_bool", i), 32'(v_bool), 32'(vecs[i].evb));
         check($sformatf("v%0d_range", i), 32'(out_range), 32'(vecs[i].rng));
         check($sformatf("v%0d_comp", i), 32'(out_comp), 32'(vecs[i].comp));
         check($sformatf("v%0d_bs", i), 32'(out_bool_symbol), 32'(vecs[i].ebs));
         check($sformatf("v%0d_done_mult_a", i), 32'(mult_a), 32'd0);
         check($sformatf("v%0d_done_mult_b", i), 32'(mult_b), 32'd0);
         check($sformatf("v%0d_done_in_ready", i), 32'(in_ready), 32'd0);
         if (vecs[i].bl) check($sformatf("v%0d_no_mul_u", i), 32'(mon_hit), 32'd0);
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         check($sformatf("v%0d_release_valid", i), 32'(out_valid), 32'd0);
         check($sformatf("v%0d_release_ready", i), 32'(in_ready), 32'd1);
      end

      // ---------------- backpressure ----------------
      send(0, lat);
      check("bp_latency", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(vecs[3]);
         in_valid = 1'b1;
         check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
         check($sformatf("bp%0d_v", c), 32'(v), 32'(vecs[0].ev));
         check($sformatf("bp%0d_u", c), 32'(u), 32'(vecs[0].eu));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) beats++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("bp_single_transfer", 32'(beats), 32'd1);
      check("bp_ignored_range", 32'(out_range), 32'(vecs[0].rng));
      check("bp_ignored_v", 32'(v), 32'(vecs[0].ev));

      // ---------------- back-to-back ----------------
      @(negedge clk);
      out_ready = 1'b1;
      k_in = 0;
      drive(vecs[seq[0]]);
      in_valid = 1'b1;
      acc_last = in_ready;
      beats = 0;
      last_c = 0;
      for (int c = 1; c < 24; c++) begin
         @(negedge clk);
         if (acc_last) begin
            k_in++;
            if (k_in < 4) drive(vecs[seq[k_in]]);
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            if (beats < 4) begin
               check($sformatf("b2b%0d_u", beats), 32'(u), 32'(vecs[seq[beats]].eu));
               check($sformatf("b2b%0d_v", beats), 32'(v), 32'(vecs[seq[beats]].ev));
               check($sformatf("b2b%0d_v_bool", beats), 32'(v_bool), 32'(vecs[seq[beats]].evb));
            end
            if (beats > 0) check($sformatf("b2b%0d_spacing", beats), 32'(c - last_c), 32'd3);
            last_c = c;
            beats++;
         end
         acc_last = in_valid && in_ready;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_beats", 32'(beats), 32'd4);

      // ---------------- reset during MUL_U ----------------
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_in_mul_u", 32'(mult_b), 32'(vecs[0].uu));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_in_ready",  32'(in_ready),  32'd0);
      check("mid_u",         32'(u),         32'd0);
      check("mid_v",         32'(v),         32'd0);
      check("mid_v_bool",    32'(v_bool),    32'd0);
      check("mid_range",     32'(out_range), 32'd0);
      check("mid_comp",      32'(out_comp),  32'd0);
      check("mid_bs",        32'(out_bool_symbol), 32'd0);
      check("mid_mult_a",    32'(mult_a),    32'd0);
      check("mid_mult_b",    32'(mult_b),    32'd0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) beats++;
      end
      out_ready = 1'b0;
      check("mid_no_emit", 32'(beats), 32'd0);
      check("mid_idle_ready", 32'(in_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_stage_2_mult_scheduler
